// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V funct3 encodings for loads/stores (F3_*)
//   - memory store-size encodings (SZ_*)
//   - FSM state type lsu_state_t
//   - helpers: access_bytes() and f3_legal()
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    STORE   = 3'd3,
    RESP    = 3'd4
  } lsu_state_t;

  // Access width in bytes; funct3[1:0] carries the size for every legal code.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: request/response bus from the core plus the data-memory port.
//   slave  : the LSU side (takes requests, drives memory)
//   master : the core + memory side (testbench)
// Handshake: a request transfers on the rising edge where req_valid && req_ready;
// req_ready is high only while the LSU is idle, and req_valid/fields are ignored
// otherwise. rsp_valid is a single-cycle pulse with no back-pressure; rsp_rdata
// and rsp_fault are valid in that cycle and held until the next response.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [1:0]  mem_store_size;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_write_en, mem_read_en, mem_addr, mem_store_size, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_write_en, mem_read_en, mem_addr, mem_store_size, mem_write_data
  );
endinterface

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: combinational load-data aligner.
//   pair   : {upper word, lower word} read from memory (upper is 0 when unused)
//   offset : byte offset of the access inside the lower word
//   funct3 : load type (B/H/W signed, BU/HU unsigned)
//   data   : selected bytes, sign- or zero-extended to 32 bits
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] pair,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] win;

  // Bring the addressed byte down to bit 0; a crossing access pulls the
  // missing bytes in from the upper word.
  assign win = 32'(pair >> {offset, 3'b000});

  always_comb begin
    data = win;
    case (funct3)
      F3_B:    data = {{24{win[7]}}, win[7:0]};
      F3_H:    data = {{16{win[15]}}, win[15:0]};
      F3_BU:   data = {24'h0, win[7:0]};
      F3_HU:   data = {16'h0, win[15:0]};
      default: data = win;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the execute stage and a little-endian,
// byte-addressed data memory (async read, sync write).
//   clk, reset : clock, synchronous active-high reset
//   bus        : lsu_mem_ctrl_if.slave (core request/response + memory port)
//   dbg_state  : current FSM state
// Parameter MEM_SIZE: memory size in bytes; any byte beyond it faults.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of
// being split into two reads or a sequence of byte writes.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 512
) (
  input  logic               clk,
  input  logic               reset,
  lsu_mem_ctrl_if.slave      bus,
  output lsu_state_t         dbg_state
);

  lsu_state_t  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, lo_q, rdata_q;
  logic        fault_q;
`ifndef LSU_MISALIGN_TRAP_EN
  logic        cross_q, mis_q;
  logic [1:0]  cnt_q;
  logic        req_crossing;
`endif

  logic [2:0]  req_size;
  logic        req_misaligned, req_range_fault, req_fault, accept;
  logic [31:0] ext_data;
  logic [63:0] ext_pair;

  // Request decode, done on the live inputs so the accept edge picks the path.
  assign req_size        = access_bytes(bus.req_funct3);
  assign req_misaligned  = (req_size == 3'd2 && bus.req_addr[0]) ||
                           (req_size == 3'd4 && bus.req_addr[1:0] != 2'b00);
  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign req_range_fault = ({1'b0, bus.req_addr} + {30'd0, req_size}) > 33'(MEM_SIZE);
`ifndef LSU_MISALIGN_TRAP_EN
  assign req_crossing    = ({2'b00, bus.req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
  assign req_fault       = req_range_fault || !f3_legal(bus.req_funct3, bus.req_we);
`else
  assign req_fault       = req_range_fault || !f3_legal(bus.req_funct3, bus.req_we) ||
                           req_misaligned;
`endif

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state_q == RESP) && !reset;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fault = fault_q;
  assign dbg_state     = state_q;

  // In LOAD_HI the lower word was captured last cycle; otherwise only the
  // word on the bus matters.
  assign ext_pair = (state_q == LOAD_HI) ? {bus.mem_read_data, lo_q}
                                         : {32'h0, bus.mem_read_data};

  lsu_load_extend u_ext (
    .pair   (ext_pair),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_comb begin
    state_d            = state_q;
    bus.mem_write_en   = 1'b0;
    bus.mem_read_en    = 1'b0;
    bus.mem_addr       = 32'h0;
    bus.mem_store_size = SZ_BYTE;
    bus.mem_write_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault)       state_d = RESP;
          else if (bus.req_we) state_d = STORE;
          else                 state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        bus.mem_read_en = 1'b1;
        bus.mem_addr    = {addr_q[31:2], 2'b00};
`ifndef LSU_MISALIGN_TRAP_EN
        state_d = cross_q ? LOAD_HI : RESP;
`else
        state_d = RESP;
`endif
      end
      LOAD_HI: begin
        bus.mem_read_en = 1'b1;
        bus.mem_addr    = {addr_q[31:2] + 30'd1, 2'b00};
        state_d         = RESP;
      end
      STORE: begin
        bus.mem_write_en = 1'b1;
        state_d          = RESP;
`ifndef LSU_MISALIGN_TRAP_EN
        if (mis_q) begin
          // One byte per cycle; H uses counts 0..1, W uses 0..3.
          bus.mem_store_size = SZ_BYTE;
          bus.mem_addr       = addr_q + 32'(cnt_q);
          bus.mem_write_data = wdata_q >> {cnt_q, 3'b000};
          if (cnt_q != ((f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3)) state_d = STORE;
        end else
`endif
        begin
          bus.mem_addr       = addr_q;
          bus.mem_write_data = wdata_q;
          case (f3_q[1:0])
            2'b00:   bus.mem_store_size = SZ_BYTE;
            2'b01:   bus.mem_store_size = SZ_HALF;
            default: bus.mem_store_size = SZ_WORD;
          endcase
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset kills the memory port in the same cycle so an in-flight store
    // cannot land one more byte on the reset edge.
    if (reset) begin
      bus.mem_write_en   = 1'b0;
      bus.mem_read_en    = 1'b0;
      bus.mem_addr       = 32'h0;
      bus.mem_store_size = SZ_BYTE;
      bus.mem_write_data = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
      cross_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`ifndef LSU_MISALIGN_TRAP_EN
            cross_q <= req_crossing;
            mis_q   <= req_misaligned;
            cnt_q   <= 2'd0;
`endif
            if (req_fault) begin
              fault_q <= 1'b1;
              rdata_q <= 32'h0;
            end
          end
        end
        LOAD_LO: begin
          lo_q <= bus.mem_read_data;
          if (state_d == RESP) begin
            rdata_q <= ext_data;
            fault_q <= 1'b0;
          end
        end
        LOAD_HI: begin
          rdata_q <= ext_data;
          fault_q <= 1'b0;
        end
        STORE: begin
`ifndef LSU_MISALIGN_TRAP_EN
          cnt_q <= cnt_q + 2'd1;
`endif
          if (state_d == RESP) begin
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a byte-array data
// memory, directed cases, randomized traffic and a mid-store reset.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int MEM_SIZE = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus();
  lsu_state_t     dbg_state;

  lsu_mem_ctrl #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- data memory ----------------
  logic [7:0] mem     [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];

  always_comb begin
    int a;
    a = int'(bus.mem_addr);
    bus.mem_read_data = 32'h0;
    if (bus.mem_addr <= 32'(MEM_SIZE - 4))
      bus.mem_read_data = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  end

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.mem_write_en) begin
      int a, n;
      a = int'(bus.mem_addr);
      n = (bus.mem_store_size == 2'b00) ? 1 : (bus.mem_store_size == 2'b01) ? 2 : 4;
      if (bus.mem_addr > 32'(MEM_SIZE - n)) begin
        checks++;
        errors++;
        $display("FAIL write_range: got addr %h expected below %0d", bus.mem_addr, MEM_SIZE);
      end else begin
        for (int k = 0; k < n; k++) mem[a+k] <= bus.mem_write_data[8*k +: 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
    logic [7:0]  lat;   // clock edges from accept to the edge that samples the response
    logic [31:0] acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  logic act = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the access is a run of size bytes at addr in a flat byte
  // array; the response timing follows from how many memory cycles it needs.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int acc);
    int          size, lat;
    longint      end_addr;
    logic        legal, fault, mis;
    logic [31:0] val;
    exp_t        x;
    size     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal    = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
               (!we && (f3 == 3'b100 || f3 == 3'b101));
    end_addr = longint'(addr) + longint'(size);
    fault    = !legal || (end_addr > longint'(MEM_SIZE));
    mis      = (addr % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) fault = 1'b1;
`endif
    val = 32'h0;
    lat = 0;
    if (!fault) begin
      if (we) begin
        for (int k = 0; k < size; k++) ref_mem[int'(addr)+k] = wdata[8*k +: 8];
        lat = mis ? 1 + size : 2;
      end else begin
        for (int k = 0; k < size; k++) val = val | (32'(ref_mem[int'(addr)+k]) << (8*k));
        if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
        if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
        lat = (((addr % 4) + size) > 4) ? 3 : 2;
      end
    end
    x.fault = fault;
    x.rdata = val;
    x.lat   = 8'(lat);
    x.acc   = 32'(acc);
    exp_q.push_back(x);
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (reset) begin
      act = 1'b0;
    end else begin
      if (bus.mem_read_en || bus.mem_write_en) act = 1'b1;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          check32("rsp_rdata", bus.rsp_rdata, e.rdata);
          check32("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
          if (!e.fault) check32("rsp_latency", 32'(cyc) - e.acc + 32'd1, 32'(e.lat));
          else          check32("fault_mem_activity", 32'(act), 32'd0);
        end
        act = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    model(we, f3, addr, wdata, cyc + 1);
    @(posedge clk);
    #1;
    // A junk request held for one busy cycle must be ignored.
    bus.req_valid  = 1'($urandom_range(0, 1));
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] f3_tab [5];

  initial begin
    int bad;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h10] = 8'h80; mem[16'h11] = 8'h7F; mem[16'h12] = 8'h34; mem[16'h13] = 8'h12;
    for (int i = 16'h10; i < 16'h14; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check32("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check32("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check32("rst_mem_en", {30'd0, bus.mem_write_en, bus.mem_read_en}, 32'd0);
    check32("rst_mem_addr", bus.mem_addr, 32'd0);
    check32("rst_mem_wdata", bus.mem_write_data, 32'd0);
    check32("rst_mem_size", 32'(bus.mem_store_size), 32'd0);
    check32("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    check32("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Directed cases
    issue(1'b0, 3'b000, 32'h10, 32'h0);          // LB  -> FFFFFF80
    issue(1'b0, 3'b100, 32'h10, 32'h0);          // LBU -> 00000080
    issue(1'b0, 3'b010, 32'h10, 32'h0);          // LW  -> 12347F80
    issue(1'b1, 3'b001, 32'h21, 32'h0000ABCD);   // SH misaligned
    issue(1'b0, 3'b101, 32'h21, 32'h0);          // LHU -> 0000ABCD
    issue(1'b1, 3'b010, 32'h1E, 32'hDEADBEEF);   // SW misaligned
    issue(1'b0, 3'b010, 32'h1E, 32'h0);          // LW crossing
    issue(1'b0, 3'b010, 32'h1FE, 32'h0);         // range fault
    issue(1'b0, 3'b011, 32'h10, 32'h0);          // illegal funct3
    issue(1'b1, 3'b100, 32'h10, 32'h12345678);   // unsigned store is illegal
    issue(1'b0, 3'b010, 32'h1FC, 32'h0);         // last word in range
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);    // no wrap on range check
    drain();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          r;
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 19);
      f3 = (r < 18) ? f3_tab[$urandom_range(0, 4)] : 3'($urandom_range(6, 7));
      r  = $urandom_range(0, 19);
      if (r < 16)      addr = 32'($urandom_range(0, 63));
      else if (r < 19) addr = 32'($urandom_range(MEM_SIZE - 16, MEM_SIZE - 1));
      else             addr = $urandom;
      issue(we, f3, addr, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset in the middle of a split word store
    issue(1'b1, 3'b010, 32'h1C, 32'hA5A5A5A5);
    issue(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5);
    drain();
    @(negedge clk);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h1E;
    bus.req_wdata  = 32'h11223344;
    @(posedge clk);                 // accepted
    #1 bus.req_valid = 1'b0;
    @(posedge clk);                 // first byte lands
    #1 reset = 1'b1;
    ref_mem[16'h1E] = 8'h44;
    @(negedge clk);
    check32("midrst_write_en", 32'(bus.mem_write_en), 32'd0);
    check32("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check32("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    check32("midrst_state", 32'(dbg_state), 32'(IDLE));
    issue(1'b0, 3'b010, 32'h1C, 32'h0);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    drain();

    bad = 0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (bad < 8) $display("byte %h differs: got %h expected %h", i, mem[i], ref_mem[i]);
        bad++;
      end
    end
    check32("mem_image_bad_bytes", 32'(bad), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
